// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV CSR loader: widths, FSM encoding and bank select.
package spmv_pkg;

  localparam int SPMV_DATA_W = 16;
  localparam int SPMV_LINE_W = 256;
  localparam int SPMV_ADDR_W = 5;
  localparam int SPMV_WORDS  = SPMV_LINE_W / SPMV_DATA_W;
  localparam int SRAM_DEPTH  = 32;
  localparam int LCNT_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  // A job must write at least one line and no more than one full bank.
  function automatic logic num_lines_ok(input logic [LCNT_W-1:0] n);
    return (n != '0) && (n <= LCNT_W'(SRAM_DEPTH));
  endfunction

endpackage

// File: rtl/spmv_line_packer.sv
// Line packer: collects DATA_W-bit words into one LINE_W-bit line, word 0 in the LSBs.
module spmv_line_packer
  import spmv_pkg::*;
#(
  parameter int DATA_W = SPMV_DATA_W,
  parameter int LINE_W = SPMV_LINE_W
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              clr,
  input  logic              accept,
  input  logic [DATA_W-1:0] data,
  output logic [LINE_W-1:0] line,
  output logic              full
);

  localparam int WORDS  = LINE_W / DATA_W;
  localparam int WCNT_W = $clog2(WORDS);

  logic [WCNT_W-1:0] wcnt;

  assign full = accept && (wcnt == WCNT_W'(WORDS - 1));

  // Store each accepted word at its slot; clear restarts an empty line.
  // NOTE: the buffer is a flop array, not a RAM, so it is reset; a partial
  // line from an aborted job must never leak into a later write.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      line <= '0;
      wcnt <= '0;
    end else if (clr) begin
      line <= '0;
      wcnt <= '0;
    end else if (accept) begin
      line[wcnt*DATA_W +: DATA_W] <= data;
      wcnt <= wcnt + 1'b1;
    end
  end

endmodule

// File: rtl/spmv_csr_loader.sv
// SpMV CSR loader: packs a host word stream into SRAM lines for bank A or B.
// Optional feature macro: SPMV_LOADER_PAD_EN (adds i_s_last, zero-pads a short final line).
module spmv_csr_loader
  import spmv_pkg::*;
#(
  parameter int DATA_W = SPMV_DATA_W,
  parameter int LINE_W = SPMV_LINE_W,
  parameter int ADDR_W = SPMV_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic              i_bank,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LCNT_W-1:0] i_num_lines,
  input  logic              i_s_valid,
  input  logic [DATA_W-1:0] i_s_data,
`ifdef SPMV_LOADER_PAD_EN
  input  logic              i_s_last,
`endif
  output logic              o_s_ready,
  output logic              o_wr_en_A,
  output logic              o_wr_en_B,
  output logic [ADDR_W-1:0] o_address_A,
  output logic [ADDR_W-1:0] o_address_B,
  output logic [LINE_W-1:0] o_write_data,
  output logic [1:0]        o_state,
  output logic              o_busy,
  output logic              o_err,
  output logic              o_done
);

  state_e              state;
  logic                bank_q;
  logic [ADDR_W-1:0]   base_q;
  logic [LCNT_W-1:0]   num_lines_q;
  logic [LCNT_W-1:0]   lcnt;
  logic                err_q;
  logic                last_q;

  logic                accept;
  logic                clr;
  logic                full;
  logic                last_acc;
  logic [LINE_W-1:0]   line;
  logic [ADDR_W-1:0]   wr_addr;

  // Ready is a pure state decode so there is no path from i_s_valid.
  assign accept  = i_s_valid && (state == ST_FILL);
  assign clr     = (state == ST_WRITE) || ((state == ST_IDLE) && i_start);
  assign wr_addr = base_q + lcnt[ADDR_W-1:0];

`ifdef SPMV_LOADER_PAD_EN
  assign last_acc = accept && i_s_last;
`else
  assign last_acc = 1'b0;
`endif

  spmv_line_packer #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W)
  ) u_packer (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .clr    (clr),
    .accept (accept),
    .data   (i_s_data),
    .line   (line),
    .full   (full)
  );

  // Job sequencer: latch job, fill lines, write each one, then pulse done.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= ST_IDLE;
      bank_q      <= BANK_A;
      base_q      <= '0;
      num_lines_q <= '0;
      lcnt        <= '0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            bank_q      <= i_bank;
            base_q      <= i_base_addr;
            num_lines_q <= i_num_lines;
            lcnt        <= '0;
            last_q      <= 1'b0;
            if (num_lines_ok(i_num_lines)) begin
              err_q <= 1'b0;
              state <= ST_FILL;
            end else begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_FILL: begin
          if (full || last_acc) begin
            last_q <= last_acc;
            state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          lcnt <= lcnt + 1'b1;
          if ((lcnt == num_lines_q - 1'b1) || last_q) state <= ST_DONE;
          else                                        state <= ST_FILL;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output decode from the state register; only the selected bank is driven.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    o_wr_en_A    = 1'b0;
    o_wr_en_B    = 1'b0;
    o_address_A  = '0;
    o_address_B  = '0;
    o_write_data = '0;
    if (state == ST_WRITE) begin
      o_write_data = line;
      if (bank_q == BANK_A) begin
        o_wr_en_A   = 1'b1;
        o_address_A = wr_addr;
      end else begin
        o_wr_en_B   = 1'b1;
        o_address_B = wr_addr;
      end
    end
  end

  assign o_s_ready = (state == ST_FILL);
  assign o_state   = state;
  assign o_busy    = (state != ST_IDLE);
  assign o_done    = (state == ST_DONE);
  assign o_err     = (state == ST_DONE) && err_q;

endmodule

// File: tb/tb_spmv_csr_loader.sv
// Self-checking bench for spmv_csr_loader with a write scoreboard.
`timescale 1ns/1ps
module tb_spmv_csr_loader;

  localparam int DW = 16;
  localparam int LW = 256;
  localparam int AW = 5;

  typedef struct {
    logic          bank;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          i_rstn;
  logic          i_start;
  logic          i_bank;
  logic [AW-1:0] i_base_addr;
  logic [5:0]    i_num_lines;
  logic          i_s_valid;
  logic [DW-1:0] i_s_data;
  logic          i_s_last;
  logic          o_s_ready;
  logic          o_wr_en_A, o_wr_en_B;
  logic [AW-1:0] o_address_A, o_address_B;
  logic [LW-1:0] o_write_data;
  logic [1:0]    o_state;
  logic          o_busy, o_err, o_done;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  int   wr_count = 0;
  int   last_wr_cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spmv_csr_loader dut (
    .i_clk        (clk),
    .i_rstn       (i_rstn),
    .i_start      (i_start),
    .i_bank       (i_bank),
    .i_base_addr  (i_base_addr),
    .i_num_lines  (i_num_lines),
    .i_s_valid    (i_s_valid),
    .i_s_data     (i_s_data),
`ifdef SPMV_LOADER_PAD_EN
    .i_s_last     (i_s_last),
`endif
    .o_s_ready    (o_s_ready),
    .o_wr_en_A    (o_wr_en_A),
    .o_wr_en_B    (o_wr_en_B),
    .o_address_A  (o_address_A),
    .o_address_B  (o_address_B),
    .o_write_data (o_write_data),
    .o_state      (o_state),
    .o_busy       (o_busy),
    .o_err        (o_err),
    .o_done       (o_done)
  );

  // Write monitor: every strobe pops the scoreboard and compares bank, address, data.
  always @(negedge clk) begin
    if (o_wr_en_A || o_wr_en_B) begin
      exp_t e;
      logic          got_bank;
      logic [AW-1:0] got_addr, idle_addr;
      wr_count++;
      last_wr_cyc = cyc;
      n_checks++;
      if (sb.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_write: wr_en_A=%0b wr_en_B=%0b addrA=%0d addrB=%0d, required no write",
                 o_wr_en_A, o_wr_en_B, o_address_A, o_address_B);
      end else begin
        e         = sb.pop_front();
        got_bank  = o_wr_en_B;
        got_addr  = o_wr_en_B ? o_address_B : o_address_A;
        idle_addr = o_wr_en_B ? o_address_A : o_address_B;
        if ((o_wr_en_A && o_wr_en_B) || got_bank !== e.bank || got_addr !== e.addr ||
            idle_addr !== '0 || o_write_data !== e.data) begin
          n_fails++;
          $display("FAIL write: bank=%0b addr=%0d other_addr=%0d data=%h, required bank=%0b addr=%0d data=%h",
                   got_bank, got_addr, idle_addr, o_write_data, e.bank, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_val(input int job, input int ln, input int k);
    return 16'((job << 12) | (ln << 8) | k);
  endfunction

  function automatic logic [LW-1:0] line_val(input int job, input int ln, input int nwords);
    logic [LW-1:0] d;
    d = '0;
    for (int k = 0; k < nwords; k++) d[16*k +: 16] = word_val(job, ln, k);
    return d;
  endfunction

  task automatic push_job(input int job, input logic bank, input int base, input int n);
    for (int l = 0; l < n; l++) begin
      exp_t e;
      e.bank = bank;
      e.addr = AW'((base + l) % 32);
      e.data = line_val(job, l, 16);
      sb.push_back(e);
    end
  endtask

  task automatic start_job(input logic bank, input int base, input int n);
    tick();
    i_start     = 1'b1;
    i_bank      = bank;
    i_base_addr = AW'(base);
    i_num_lines = 6'(n);
    tick();
    i_start     = 1'b0;
    i_bank      = ~bank;
    i_base_addr = 5'd17;
    i_num_lines = 6'd9;
  endtask

  // Present one word and hold it until accepted; optional idle gap and stray start first.
  task automatic send_word(input logic [15:0] d, input logic last, input int max_gap, input bit poke);
    bit acc;
    int gap;
    if (poke) begin
      i_s_valid   = 1'b0;
      i_start     = 1'b1;
      i_bank      = 1'b1;
      i_base_addr = 5'd0;
      i_num_lines = 6'd5;
      tick();
      i_start     = 1'b0;
    end
    if (max_gap > 0) begin
      gap       = $urandom_range(max_gap, 0);
      i_s_valid = 1'b0;
      repeat (gap) tick();
    end
    i_s_valid = 1'b1;
    i_s_data  = d;
    i_s_last  = last;
    acc = 1'b0;
    for (int b = 0; b < 50 && !acc; b++) begin
      acc = o_s_ready;
      tick();
    end
    if (!acc) begin
      n_checks++;
      n_fails++;
      $display("FAIL ready_timeout: word %h not accepted within 50 cycles", d);
    end
  endtask

  task automatic stream_job(input int job, input int n, input int max_gap, input bit pokes);
    for (int l = 0; l < n; l++)
      for (int k = 0; k < 16; k++)
        send_word(word_val(job, l, k), 1'b0, max_gap,
                  pokes && ((l == 0 && k == 3) || (l == 1 && k == 0)));
    i_s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic exp_err, output int waited);
    bit seen = 1'b0;
    waited = 0;
    for (int b = 0; b < 60 && !seen; b++) begin
      @(negedge clk);
      waited++;
      if (o_done) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fails++;
      $display("FAIL %s_done: no done pulse within 60 cycles, required a pulse", name);
    end else if (o_err !== exp_err) begin
      n_fails++;
      $display("FAIL %s_err: o_err=%0b, required %0b", name, o_err, exp_err);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({o_state, o_busy, o_s_ready, o_wr_en_A, o_wr_en_B, o_address_A, o_address_B,
         o_err, o_done} !== '0 || o_write_data !== '0) begin
      n_fails++;
      $display("FAIL %s: state=%0d busy=%0b ready=%0b wrA=%0b wrB=%0b addrA=%0d addrB=%0d err=%0b done=%0b data=%h, required all 0",
               name, o_state, o_busy, o_s_ready, o_wr_en_A, o_wr_en_B, o_address_A, o_address_B,
               o_err, o_done, o_write_data);
    end
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_start = 1'b0; i_bank = 1'b0; i_base_addr = '0; i_num_lines = '0;
    i_s_valid = 1'b0; i_s_data = '0; i_s_last = 1'b0;
    #3;
    check_all_zero("reset_outputs");
    tick();
    i_rstn = 1'b1;
    tick();
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_bank_a_single();
    int waited, wr0;
    wr0 = wr_count;
    push_job(0, 1'b0, 0, 1);
    start_job(1'b0, 0, 1);
    n_checks++;
    if (o_state !== 2'd1 || o_busy !== 1'b1 || o_s_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL a_first_ready: state=%0d busy=%0b ready=%0b, required 1 1 1", o_state, o_busy, o_s_ready);
    end
    stream_job(0, 1, 0, 1'b0);
    wait_done("a_single", 1'b0, waited);
    n_checks++;
    if (cyc !== last_wr_cyc + 1) begin
      n_fails++;
      $display("FAIL a_done_latency: done in cycle %0d, required %0d", cyc, last_wr_cyc + 1);
    end
    n_checks++;
    if (wr_count - wr0 !== 1) begin
      n_fails++;
      $display("FAIL a_write_count: %0d writes, required 1", wr_count - wr0);
    end
  endtask

  task automatic test_bank_b_wrap();
    int waited, first_ready, wr0;
    wr0 = wr_count;
    push_job(1, 1'b1, 30, 3);
    start_job(1'b1, 30, 3);
    first_ready = cyc;
    stream_job(1, 3, 0, 1'b0);
    wait_done("b_wrap", 1'b0, waited);
    // 51 cycles inclusive: three lines of 16 accepts plus one write each.
    n_checks++;
    if (last_wr_cyc - first_ready + 1 !== 51) begin
      n_fails++;
      $display("FAIL b_throughput: %0d cycles first ready to last write, required 51",
               last_wr_cyc - first_ready + 1);
    end
    n_checks++;
    if (wr_count - wr0 !== 3 || sb.size() !== 0) begin
      n_fails++;
      $display("FAIL b_write_count: %0d writes, %0d pending, required 3 and 0", wr_count - wr0, sb.size());
    end
  endtask

  task automatic test_gaps_and_restart();
    int waited, wr0;
    wr0 = wr_count;
    push_job(2, 1'b0, 2, 2);
    start_job(1'b0, 2, 2);
    stream_job(2, 2, 3, 1'b1);
    wait_done("gaps", 1'b0, waited);
    tick();
    n_checks++;
    if (o_busy !== 1'b0 || wr_count - wr0 !== 2 || sb.size() !== 0) begin
      n_fails++;
      $display("FAIL gaps_restart_ignored: busy=%0b writes=%0d pending=%0d, required 0 2 0",
               o_busy, wr_count - wr0, sb.size());
    end
  endtask

  task automatic test_bad_num_lines();
    int waited, wr0;
    int bad[2] = '{0, 40};
    foreach (bad[i]) begin
      wr0 = wr_count;
      start_job(1'b0, 4, bad[i]);
      wait_done($sformatf("bad_n%0d", bad[i]), 1'b1, waited);
      n_checks++;
      if (waited !== 1 || wr_count !== wr0) begin
        n_fails++;
        $display("FAIL bad_n%0d_timing: done after %0d cycles with %0d writes, required 1 and 0",
                 bad[i], waited, wr_count - wr0);
      end
    end
  endtask

  task automatic test_reset_midjob();
    int waited, wr0;
    wr0 = wr_count;
    push_job(3, 1'b0, 5, 2);
    start_job(1'b0, 5, 3);
    stream_job(3, 2, 0, 1'b0);
    for (int k = 0; k < 7; k++) send_word(word_val(3, 2, k), 1'b0, 0, 1'b0);
    i_rstn = 1'b0;
    #1;
    check_all_zero("midjob_reset_outputs");
    i_s_valid = 1'b0;
    repeat (3) tick();
    i_rstn = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (wr_count - wr0 !== 2 || sb.size() !== 0 || o_done !== 1'b0) begin
      n_fails++;
      $display("FAIL midjob_no_write: writes=%0d pending=%0d done=%0b, required 2 0 0",
               wr_count - wr0, sb.size(), o_done);
    end
    push_job(4, 1'b1, 7, 1);
    start_job(1'b1, 7, 1);
    stream_job(4, 1, 0, 1'b0);
    wait_done("after_reset", 1'b0, waited);
    n_checks++;
    if (wr_count - wr0 !== 3 || sb.size() !== 0) begin
      n_fails++;
      $display("FAIL after_reset_write: writes=%0d pending=%0d, required 3 0", wr_count - wr0, sb.size());
    end
  endtask

`ifdef SPMV_LOADER_PAD_EN
  task automatic test_pad_last();
    int waited, wr0;
    exp_t e;
    wr0 = wr_count;
    e.bank = 1'b0;
    e.addr = 5'd9;
    e.data = line_val(5, 0, 5);
    sb.push_back(e);
    start_job(1'b0, 9, 4);
    for (int k = 0; k < 5; k++) send_word(word_val(5, 0, k), (k == 4), 0, 1'b0);
    i_s_valid = 1'b0;
    i_s_last  = 1'b0;
    wait_done("pad", 1'b0, waited);
    n_checks++;
    if (wr_count - wr0 !== 1 || sb.size() !== 0) begin
      n_fails++;
      $display("FAIL pad_write_count: writes=%0d pending=%0d, required 1 0", wr_count - wr0, sb.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bank_a_single();
    test_bank_b_wrap();
    test_gaps_and_restart();
    test_bad_num_lines();
    test_reset_midjob();
`ifdef SPMV_LOADER_PAD_EN
    test_pad_last();
`endif
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/spmv_csr_loader.md
# spmv_csr_loader

Upstream fill stage for the SpMV engine. It accepts a host stream of 16-bit words over a valid/ready handshake and packs 16 consecutive words into one 256-bit line. Each completed line is written into either M10K bank A (input vector / matrix values) or bank B (row_ptr / col_idx) at a programmed base address. Its `o_done` pulse is the trigger for the operator's `i_start`.

## Interface
Parameters:
- DATA_W, 16, stream word width
- LINE_W, 256, SRAM line width; WORDS = LINE_W/DATA_W = 16
- ADDR_W, 5, SRAM address width (32 lines per bank)

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_start  in  1  single-cycle pulse that starts a job; sampled only in IDLE
- i_bank  in  1  target bank: 0 = A, 1 = B; latched at start
- i_base_addr  in  ADDR_W  first line address; latched at start
- i_num_lines  in  6  lines in the job; legal range 1..32; latched at start
- i_s_valid  in  1  stream word valid
- i_s_data  in  DATA_W  stream word
- i_s_last  in  1  last word of stream; present only with SPMV_LOADER_PAD_EN
- o_s_ready  out  1  loader accepts a word this cycle
- o_wr_en_A / o_wr_en_B  out  1  bank write strobes
- o_address_A / o_address_B  out  ADDR_W  bank write addresses
- o_write_data  out  LINE_W  packed line, shared by both banks
- o_state  out  2  FSM state
- o_busy  out  1  state != IDLE
- o_err  out  1  job rejected; valid with o_done
- o_done  out  1  single-cycle job completion pulse

## Operation
- States: IDLE=0, FILL=1, WRITE=2, DONE=3.
- IDLE:
  - On i_start, latch i_bank, i_base_addr and i_num_lines, clear the line buffer, word count and line count.
  - i_num_lines of 0 or greater than 32: set err, go to DONE, perform no writes.
  - Otherwise go to FILL.
- FILL:
  - o_s_ready = 1.
  - Each word accepted (i_s_valid & o_s_ready) is stored at buffer bits [16*wcnt +: 16]; word 0 occupies the LSBs, matching the downstream slice `col_idx*16`.
  - wcnt increments on each accept. The accept with wcnt == 15 goes to WRITE.
- WRITE:
  - o_s_ready = 0.
  - The selected bank's wr_en = 1, its address = (base + lcnt) mod 32 (wraps past 31), o_write_data = buffer.
  - Then clear the buffer and wcnt and increment lcnt.
  - If lcnt == num_lines-1, go to DONE; otherwise go to FILL.
- DONE: o_done = 1, o_err = err, then return to IDLE.
- The unselected bank's wr_en stays 0. Both address outputs are 0 when not in WRITE.
- i_start outside IDLE is ignored.
- Words presented while ready = 0 are not consumed; the host must hold them.

## Timing
- Reset values: state IDLE; every output 0; buffer, counters and err cleared.
- Reset mid-job discards any partial line and suppresses its write; no done pulse follows.
- Start to first ready: 1 cycle (i_start at edge t puts the FSM in FILL for cycle t+1).
- The 16th word accepted at edge t produces the write strobe during cycle t+1. Write is one cycle.
- Back-to-back valid input gives 17 cycles per line.
- o_done is asserted the cycle after the final WRITE.
- o_s_ready depends only on state (no combinational path from i_s_valid).

## Configuration
- Macro SPMV_LOADER_PAD_EN.
- Defined:
  - i_s_last exists.
  - An accepted word with i_s_last = 1 forces WRITE with the unfilled words as zero, then DONE regardless of the remaining line count.
  - A last on word 15 behaves as a normal full line.
- Undefined:
  - The port is absent.
  - A job always ends after exactly num_lines full lines.

## Structure
- Package spmv_pkg: state encodings, DATA_W / LINE_W / ADDR_W, WORDS, SRAM depth 32, bank select constants.
- Sub-module spmv_line_packer: word counter, line buffer, clear/accept/full signals.
- The FSM, line counter and address generation stay in the top.

## Test plan
- Bank A job, base 0, num_lines 1, words 0x0000..0x000F with continuous valid:
  - Exactly one wr_en_A pulse, at address 0, with data word k = k at bits [16k+15:16k].
  - o_done follows 1 cycle later; wr_en_B stays 0.
- Bank B job, base 30, num_lines 3:
  - Writes occur at addresses 30, 31, 0 (wrap).
  - 51 cycles from the first ready to the last write.
- Random valid gaps and i_start pulsed mid-job:
  - Data is identical to the gap-free run.
  - The extra start has no effect.
- i_num_lines = 0 and = 40: o_done and o_err both high 1 cycle after start, no writes.
- i_rstn asserted after 7 words of line 2:
  - All outputs are 0 immediately, no write occurs.
  - A new job afterwards writes clean data.
- With SPMV_LOADER_PAD_EN, num_lines 4, last on the 5th word of line 0:
  - One write with words 0..4 set and words 5..15 zero, then o_done.
